// File: rtl/lf_pkg.sv
// Shared encodings and arithmetic helpers for the line-follower controller.
package lf_pkg;

    // FSM state codes (visible on the state output)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_SEARCH = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Motor direction codes: bit1 = motor A (left) forward, bit0 = motor B (right) forward
    localparam logic [1:0] MOT_OFF         = 2'b00;
    localparam logic [1:0] MOT_FWD         = 2'b11;
    localparam logic [1:0] MOT_PIVOT_LEFT  = 2'b01;
    localparam logic [1:0] MOT_PIVOT_RIGHT = 2'b10;

    // Side on which the line was last seen
    localparam logic SIDE_LEFT  = 1'b1;
    localparam logic SIDE_RIGHT = 1'b0;

    // Clamp a signed duty request into [0, max_value]
    function automatic int sat_duty(input int value, input int max_value);
        if (value < 0) begin
            return 0;
        end
        if (value > max_value) begin
            return max_value;
        end
        return value;
    endfunction

    // One ramp step toward tgt, limited to step; a zero target is taken at once
    function automatic int ramp_toward(input int cur, input int tgt, input int step);
        int delta;
        if (tgt == 0) begin
            return 0;
        end
        delta = tgt - cur;
        if (delta > step) begin
            return cur + step;
        end
        if (delta < -step) begin
            return cur - step;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM generator: out is high while the counter is below duty.
module pwm_gen #(
    parameter int unsigned DUTY_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] duty,
    output logic              wrap,
    output logic              out
);

    logic [DUTY_W-1:0] cnt;

    // Period counter and registered compare
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            out <= 1'b0;
        end else begin
            cnt <= cnt + DUTY_W'(1);
            out <= (cnt < duty);
        end
    end

    // Last clock of the period; the applied duty changes on the following edge
    assign wrap = &cnt;

endmodule

// File: rtl/line_follow_ctrl.sv
// Inductive-sensor line follower: input filtering, steering FSM, duty ramp and PWM.
module line_follow_ctrl
    import lf_pkg::*;
#(
    parameter int unsigned N_SENS       = 3,
    parameter int unsigned DUTY_W       = 12,
    parameter int unsigned BASE_DUTY    = 1700,
    parameter int unsigned K_STEER      = 600,
    parameter int unsigned FILT_LEN     = 4,
    parameter int unsigned RAMP_STEP    = 256,
    parameter int unsigned SEARCH_DUTY  = 1200,
    parameter int unsigned LOST_TIMEOUT = 2**20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_SENS-1:0] ips,
    output logic              ENA,
    output logic              ENB,
    output logic [1:0]        motors,
    output logic [N_SENS-1:0] led,
    output logic [1:0]        state
);

    localparam int unsigned HALF     = N_SENS / 2;
    localparam int unsigned FCW      = $clog2(FILT_LEN + 1);
    localparam int unsigned TMR_W    = $clog2(LOST_TIMEOUT + 1);
    localparam int unsigned DUTY_MAX = (2**DUTY_W) - 1;
    localparam logic [N_SENS-1:0] LOW_MASK  = N_SENS'((2**HALF) - 1);
    localparam logic [N_SENS-1:0] HIGH_MASK = LOW_MASK << (N_SENS - HALF);

    logic [N_SENS-1:0] filt;
    int                diff;
    logic              all_ones;
    logic              all_zeros;

    logic [1:0]        state_next;
    logic [1:0]        motors_next;
    logic [DUTY_W-1:0] tgt_a, tgt_a_next;
    logic [DUTY_W-1:0] tgt_b, tgt_b_next;
    logic              last_side, side_next;
    logic [TMR_W-1:0]  timer, timer_next;

    logic [DUTY_W-1:0] duty_a;
    logic [DUTY_W-1:0] duty_b;
    logic              wrap_a;
    logic              wrap_b;

    // Per-bit stability filter: accept a new level after FILT_LEN differing cycles
    for (genvar g = 0; g < N_SENS; g++) begin : g_filt
        logic           bit_q;
        logic [FCW-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                bit_q <= 1'b1;
                cnt_q <= '0;
            end else if (ips[g] == bit_q) begin
                cnt_q <= '0;
            end else if (cnt_q == FCW'(FILT_LEN - 1)) begin
                bit_q <= ips[g];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + FCW'(1);
            end
        end

        assign filt[g] = bit_q;
    end

    assign led       = filt;
    assign all_ones  = &filt;
    assign all_zeros = ~|filt;

    // Steering error: zeros on the left half minus zeros on the right half
    assign diff = $countones(~filt & HIGH_MASK) - $countones(~filt & LOW_MASK);

    // Next state, side memory, lost timer and per-state motor/target outputs
    always_comb begin
        state_next  = state;
        motors_next = MOT_OFF;
        tgt_a_next  = '0;
        tgt_b_next  = '0;
        side_next   = last_side;
        timer_next  = '0;

        if (state == ST_TRACK) begin
            if (diff > 0) begin
                side_next = SIDE_LEFT;
            end else if (diff < 0) begin
                side_next = SIDE_RIGHT;
            end
        end

        if (!en) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_TRACK;
                ST_TRACK: begin
                    if (all_zeros) begin
                        state_next = ST_STOP;
                    end else if (all_ones) begin
                        state_next = ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (all_zeros) begin
                        state_next = ST_STOP;
                    end else if (!all_ones) begin
                        state_next = ST_TRACK;
                    end else if (timer == TMR_W'(LOST_TIMEOUT - 1)) begin
                        state_next = ST_STOP;
                    end
                end
                ST_STOP: state_next = ST_STOP;
                default: state_next = ST_IDLE;
            endcase
        end

        if ((state == ST_SEARCH) && (state_next == ST_SEARCH)) begin
            timer_next = timer + TMR_W'(1);
        end

        case (state_next)
            ST_TRACK: begin
                motors_next = MOT_FWD;
                tgt_a_next  = DUTY_W'(sat_duty(int'(BASE_DUTY) + int'(K_STEER) * diff, int'(DUTY_MAX)));
                tgt_b_next  = DUTY_W'(sat_duty(int'(BASE_DUTY) - int'(K_STEER) * diff, int'(DUTY_MAX)));
            end
            ST_SEARCH: begin
                if (side_next == SIDE_LEFT) begin
                    motors_next = MOT_PIVOT_LEFT;
                    tgt_b_next  = DUTY_W'(sat_duty(int'(SEARCH_DUTY), int'(DUTY_MAX)));
                end else begin
                    motors_next = MOT_PIVOT_RIGHT;
                    tgt_a_next  = DUTY_W'(sat_duty(int'(SEARCH_DUTY), int'(DUTY_MAX)));
                end
            end
            default: begin
                motors_next = MOT_OFF;
            end
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            motors    <= MOT_OFF;
            tgt_a     <= '0;
            tgt_b     <= '0;
            last_side <= SIDE_LEFT;
            timer     <= '0;
        end else begin
            state     <= state_next;
            motors    <= motors_next;
            tgt_a     <= tgt_a_next;
            tgt_b     <= tgt_b_next;
            last_side <= side_next;
            timer     <= timer_next;
        end
    end

    // Applied duty A: ramps at period boundaries, dropped at once when disabled
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            duty_a <= '0;
        end else if (wrap_a) begin
            duty_a <= DUTY_W'(ramp_toward(int'(duty_a), int'(tgt_a), int'(RAMP_STEP)));
        end
    end

    // Applied duty B: same policy as A
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            duty_b <= '0;
        end else if (wrap_b) begin
            duty_b <= DUTY_W'(ramp_toward(int'(duty_b), int'(tgt_b), int'(RAMP_STEP)));
        end
    end

    pwm_gen #(.DUTY_W(DUTY_W)) u_pwm_a (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty_a),
        .wrap  (wrap_a),
        .out   (ENA)
    );

    pwm_gen #(.DUTY_W(DUTY_W)) u_pwm_b (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty_b),
        .wrap  (wrap_b),
        .out   (ENB)
    );

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Self-checking bench for line_follow_ctrl (N_SENS=3, DUTY_W=12, RAMP_STEP=256).
module tb_line_follow_ctrl;

    localparam int unsigned N    = 3;
    localparam int unsigned DW   = 12;
    localparam int unsigned LOST = 9000;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_SEARCH = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [N-1:0] ips;
    logic         ENA;
    logic         ENB;
    logic [1:0]   motors;
    logic [N-1:0] led;
    logic [1:0]   state;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_a_q[$];
    int exp_b_q[$];

    always #5 clk = ~clk;

    line_follow_ctrl #(
        .N_SENS       (N),
        .DUTY_W       (DW),
        .BASE_DUTY    (1700),
        .K_STEER      (600),
        .FILT_LEN     (4),
        .RAMP_STEP    (256),
        .SEARCH_DUTY  (1200),
        .LOST_TIMEOUT (LOST)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .ips    (ips),
        .ENA    (ENA),
        .ENB    (ENB),
        .motors (motors),
        .led    (led),
        .state  (state)
    );

    // Stop at the last negedge of a PWM period (bounded)
    task automatic wait_wrap();
        bit seen = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (dut.wrap_a === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wrap_timeout: no PWM wrap within 5000 cycles");
        end
    endtask

    // Pop scoreboard entries, one pair per PWM period
    task automatic drain_scoreboard(input string tag);
        int ea;
        int eb;
        while (exp_a_q.size() != 0) begin
            wait_wrap();
            @(negedge clk);
            ea = exp_a_q.pop_front();
            eb = exp_b_q.pop_front();
            n_checks++;
            if (int'(dut.duty_a) !== ea) begin
                n_fail++;
                $display("FAIL %s_duty_a: got %0d expected %0d", tag, dut.duty_a, ea);
            end
            n_checks++;
            if (int'(dut.duty_b) !== eb) begin
                n_fail++;
                $display("FAIL %s_duty_b: got %0d expected %0d", tag, dut.duty_b, eb);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        ips   = 3'b111;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
        n_checks++;
        if (motors !== 2'b00) begin n_fail++; $display("FAIL reset_motors: got %b expected 00", motors); end
        n_checks++;
        if ({ENA, ENB} !== 2'b00) begin n_fail++; $display("FAIL reset_pwm: got %b expected 00", {ENA, ENB}); end
        n_checks++;
        if (led !== 3'b111) begin n_fail++; $display("FAIL reset_led: got %b expected 111", led); end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        ips = 3'b011;
        repeat (6) @(negedge clk);
        n_checks++;
        if (led !== 3'b011) begin n_fail++; $display("FAIL ramp_led: got %b expected 011", led); end
        en = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (state !== S_TRACK) begin n_fail++; $display("FAIL ramp_state: got %0d expected %0d", state, S_TRACK); end
        n_checks++;
        if (motors !== 2'b11) begin n_fail++; $display("FAIL ramp_motors: got %b expected 11", motors); end
        // targets A=2300, B=1100 reached in 256 steps from 0
        exp_a_q = '{256, 512, 768, 1024, 1280, 1536, 1792, 2048, 2300};
        exp_b_q = '{256, 512, 768, 1024, 1100, 1100, 1100, 1100, 1100};
        drain_scoreboard("ramp");
    endtask

    task automatic test_track();
        int ha;
        int hb;
        // starts just after a wrap, so the next wrap sees the new targets
        ips = 3'b101;
        repeat (6) @(negedge clk);
        n_checks++;
        if (led !== 3'b101) begin n_fail++; $display("FAIL track_led: got %b expected 101", led); end
        exp_a_q = '{2044, 1788, 1700};
        exp_b_q = '{1356, 1612, 1700};
        drain_scoreboard("track");
        ha = int'(ENA);
        hb = int'(ENB);
        repeat (4095) begin
            @(negedge clk);
            ha += int'(ENA);
            hb += int'(ENB);
        end
        n_checks++;
        if (ha != 1700) begin n_fail++; $display("FAIL track_ena_high: got %0d expected 1700", ha); end
        n_checks++;
        if (hb != 1700) begin n_fail++; $display("FAIL track_enb_high: got %0d expected 1700", hb); end
    endtask

    task automatic test_glitch();
        ips = 3'b111;
        repeat (3) @(negedge clk);
        ips = 3'b101;
        repeat (5) @(negedge clk);
        n_checks++;
        if (led !== 3'b101) begin n_fail++; $display("FAIL glitch_led: got %b expected 101", led); end
        n_checks++;
        if (state !== S_TRACK) begin n_fail++; $display("FAIL glitch_state: got %0d expected %0d", state, S_TRACK); end
    endtask

    task automatic test_search();
        ips = 3'b011;
        repeat (8) @(negedge clk);
        ips = 3'b111;
        repeat (8) @(negedge clk);
        n_checks++;
        if (state !== S_SEARCH) begin n_fail++; $display("FAIL search_state: got %0d expected %0d", state, S_SEARCH); end
        n_checks++;
        if (motors !== 2'b01) begin n_fail++; $display("FAIL search_motors: got %b expected 01", motors); end
        // A target 0 applied at once, B ramps 1700 -> 1444 -> 1200
        exp_a_q = '{0, 0};
        exp_b_q = '{1444, 1200};
        drain_scoreboard("search");
        n_checks++;
        if (state !== S_SEARCH) begin n_fail++; $display("FAIL search_hold: got %0d expected %0d", state, S_SEARCH); end
        ips = 3'b110;
        repeat (6) @(negedge clk);
        n_checks++;
        if (state !== S_TRACK) begin n_fail++; $display("FAIL search_return: got %0d expected %0d", state, S_TRACK); end
        n_checks++;
        if (motors !== 2'b11) begin n_fail++; $display("FAIL search_return_motors: got %b expected 11", motors); end
    endtask

    task automatic test_timeout();
        int s_in = -1;
        int s_out = -1;
        logic [1:0] pivot = 2'bxx;
        int highs = 0;
        ips = 3'b111;
        for (int i = 0; i < int'(LOST) + 300; i++) begin
            @(negedge clk);
            if (state === S_SEARCH && s_in < 0) begin
                s_in  = i;
                pivot = motors;
            end
            if (state === S_STOP) begin
                s_out = i;
                break;
            end
        end
        n_checks++;
        if (pivot !== 2'b10) begin n_fail++; $display("FAIL timeout_pivot_right: got %b expected 10", pivot); end
        n_checks++;
        if (s_in < 0 || s_out < 0 || (s_out - s_in) != int'(LOST)) begin
            n_fail++;
            $display("FAIL timeout_search_len: got %0d expected %0d (entry %0d exit %0d)", s_out - s_in, LOST, s_in, s_out);
        end
        n_checks++;
        if (motors !== 2'b00) begin n_fail++; $display("FAIL timeout_motors: got %b expected 00", motors); end
        wait_wrap();
        repeat (512) begin
            @(negedge clk);
            highs += int'(ENA) + int'(ENB);
        end
        n_checks++;
        if (highs != 0) begin n_fail++; $display("FAIL stop_pwm_high: got %0d expected 0", highs); end
    endtask

    task automatic test_stop_zero();
        en  = 1'b0;
        ips = 3'b101;
        @(negedge clk);
        n_checks++;
        if (state !== S_IDLE) begin n_fail++; $display("FAIL disable_state: got %0d expected %0d", state, S_IDLE); end
        repeat (6) @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (state !== S_TRACK) begin n_fail++; $display("FAIL resume_state: got %0d expected %0d", state, S_TRACK); end
        ips = 3'b000;
        repeat (6) @(negedge clk);
        n_checks++;
        if (state !== S_STOP) begin n_fail++; $display("FAIL zeros_state: got %0d expected %0d", state, S_STOP); end
        n_checks++;
        if (motors !== 2'b00) begin n_fail++; $display("FAIL zeros_motors: got %b expected 00", motors); end
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut.duty_a !== '0 || dut.duty_b !== '0) begin
            n_fail++;
            $display("FAIL disable_duty: got %0d/%0d expected 0/0", dut.duty_a, dut.duty_b);
        end
    endtask

    task automatic test_reset_mid_ramp();
        ips = 3'b101;
        repeat (6) @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
        wait_wrap();
        @(negedge clk);
        n_checks++;
        if (dut.duty_a == '0 || int'(dut.duty_a) > 512) begin
            n_fail++;
            $display("FAIL midramp_duty: got %0d expected 256 or 512", dut.duty_a);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (ENA !== 1'b1) begin n_fail++; $display("FAIL midramp_ena: got %b expected 1", ENA); end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (state !== S_IDLE) begin n_fail++; $display("FAIL midreset_state: got %0d expected %0d", state, S_IDLE); end
        n_checks++;
        if (motors !== 2'b00) begin n_fail++; $display("FAIL midreset_motors: got %b expected 00", motors); end
        n_checks++;
        if ({ENA, ENB} !== 2'b00) begin n_fail++; $display("FAIL midreset_pwm: got %b expected 00", {ENA, ENB}); end
        n_checks++;
        if (led !== 3'b111) begin n_fail++; $display("FAIL midreset_led: got %b expected 111", led); end
        n_checks++;
        if (dut.duty_a !== '0) begin n_fail++; $display("FAIL midreset_duty: got %0d expected 0", dut.duty_a); end
        rst_n = 1'b1;
        en    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_track();
        test_glitch();
        test_search();
        test_timeout();
        test_stop_zero();
        test_reset_mid_ramp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded 5 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/line_follow_ctrl.md
LINE_FOLLOW_CTRL -- requirements
Module: line_follow_ctrl

Interface
REQ-001 The block SHALL have parameter N_SENS, default 3, meaning the number of inductive sensors (3..16).
REQ-002 The block SHALL have parameter DUTY_W, default 12, meaning the duty/PWM counter width; PWM period is 2^DUTY_W clocks.
REQ-003 The block SHALL have parameter BASE_DUTY, default 1700, meaning the forward duty when centred.
REQ-004 The block SHALL have parameter K_STEER, default 600, meaning the duty offset per unit of steering error.
REQ-005 The block SHALL have parameter FILT_LEN, default 4, meaning the cycles a sensor bit must stay stable before it is accepted.
REQ-006 The block SHALL have parameter RAMP_STEP, default 256, meaning the maximum change in applied duty per PWM period.
REQ-007 The block SHALL have parameter SEARCH_DUTY, default 1200, meaning the pivot duty while the line is lost.
REQ-008 The block SHALL have parameter LOST_TIMEOUT, default 2^20, meaning the maximum SEARCH duration in clocks.
REQ-009 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-010 The block SHALL have port rst_n, input, width 1: reset, synchronous and active-low.
REQ-011 The block SHALL have port en, input, width 1: run enable.
REQ-012 The block SHALL have port ips, input, width N_SENS: raw sensor bits, where 0 means metal/line under the sensor and bit N_SENS-1 is leftmost.
REQ-013 The block SHALL have port ENA and port ENB, outputs, width 1 each: PWM enables for motor A (left) and motor B (right).
REQ-014 The block SHALL have port motors, output, width 2: direction, where bit1 is A forward and bit0 is B forward; 11 = both forward, 00 = both off.
REQ-015 The block SHALL have port led, output, width N_SENS: the filtered sensor vector.
REQ-016 The block SHALL have port state, output, width 2: the current FSM state code.

Function
REQ-017 Each ips bit SHALL pass through an independent stability filter: the filtered bit updates only after the raw bit has differed from it for FILT_LEN consecutive cycles.
REQ-018 The steering error SHALL be computed as diff = (zeros in the upper floor(N_SENS/2) bits) − (zeros in the lower floor(N_SENS/2) bits), signed; for odd N_SENS the middle bit is excluded.
REQ-019 In TRACK, the targets SHALL be tgtA = BASE_DUTY + K_STEER*diff and tgtB = BASE_DUTY − K_STEER*diff, each saturated to [0, 2^DUTY_W−1], with motors = 11.
REQ-020 The FSM SHALL have the states IDLE=0, TRACK=1, SEARCH=2 and STOP=3.
REQ-021 From any state, en=0 SHALL cause a transition to IDLE on the next clock, with motors=00, targets 0 and applied duty forced to 0 immediately.
REQ-022 IDLE SHALL transition to TRACK when en=1.
REQ-023 TRACK SHALL go to SEARCH when the filtered vector is all ones, SHALL go to STOP when it is all zeros, and SHALL otherwise remain in TRACK.
REQ-024 The block SHALL record last_side, set to left when diff>0 and to right when diff<0 (unchanged when diff=0), updated every cycle in TRACK.
REQ-025 SEARCH SHALL pivot toward last_side: left gives motors=01, right gives motors=10, with the active-wheel duty SEARCH_DUTY and the other wheel 0.
REQ-026 SEARCH SHALL return to TRACK as soon as any filtered bit is 0, and on a LOST_TIMEOUT count SHALL go to STOP; the timer clears on SEARCH entry.
REQ-027 In STOP, motors and targets SHALL be 0, and STOP SHALL be left only via en=0.
REQ-028 Applied duty SHALL update only at the PWM counter wrap, moving toward the target by min(|tgt−applied|, RAMP_STEP), except that a target of 0 is applied at the wrap without ramping.
REQ-029 PWM SHALL use a free-running DUTY_W-bit counter with out = (cnt < applied); applied=0 gives a constant 0 and applied=2^DUTY_W−1 gives high on all but one clock per period.
REQ-030 Simultaneous events SHALL be prioritised en=0 > all-zeros > all-ones > timeout.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, motors=00, ENA=ENB=0, both duties=0, the PWM counter=0, the filters and led to all ones, the filter counters and timer to 0, and last_side to left.
REQ-032 Reset asserted mid-operation SHALL take effect on the next edge with no ramp-down.

Structure
REQ-033 The state encodings, motor direction codes and the last_side encoding SHALL reside in the shared package lf_pkg.
REQ-034 PWM generation SHALL be the single sub-module pwm_gen (parameter DUTY_W; ports clk, rst_n, duty, wrap, out), instantiated once per wheel.

Verification
REQ-035 With N=3, RAMP_STEP=4095 and en=1, holding ips=101 SHALL give state=TRACK, motors=11 and ENA and ENB duty 1700/4096 after the second wrap.
REQ-036 ips=011 held SHALL give targets A=2300 and B=1100; with RAMP_STEP=256, applied A SHALL step 0, 256, 512 … 2300 at successive wraps.
REQ-037 A 3-cycle glitch of ips 101→111→101 with FILT_LEN=4 SHALL leave led and state unchanged.
REQ-038 The sequence 011 then 111 SHALL give SEARCH with motors=01 and A duty 0, B duty 1200; ips=110 SHALL then return the block to TRACK.
REQ-039 ips=111 held past LOST_TIMEOUT SHALL give STOP with ENA=ENB=0; ips=000 SHALL give STOP; en=0 followed by en=1 SHALL resume TRACK.
REQ-040 rst_n=0 asserted mid-ramp SHALL give all outputs at reset values on the next edge.
